sobel_window_filter: RTL and testbench
======================================

// Module: sobel_window_filter
// PURPOSE
//  Consumes the 3x3 neighbourhood pixel stream read from image SRAM by the window-address
//  sequencer (9 taps per window, raster order, top-left first). Computes Sobel gradient
//  magnitude |Gx|+|Gy|, saturates it and thresholds it to an edge flag.
//  Emits one result per window, tagged with the window centre (x,y). Sits directly downstream of the SRAM read port.
// PARAMETERS
//  PIX_W   8    pixel bits used; pix_in[PIX_W-1:0] taken, upper bits ignored
//  OUT_W   8    magnitude output width; saturates at 2^OUT_W-1
//  THRESH  128  edge_out=1 when saturated magnitude >= THRESH
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  pix_in     in   16     SRAM read data (tap pixel)
//  pix_valid  in   1      pix_in holds a valid tap this cycle
//  win_start  in   1      qualifies pix_valid: this tap is tap0 (top-left) of a new window
//  x_in,y_in  in   8 each window centre coordinates; sampled with tap0
//  mag_out    out  OUT_W  saturated |Gx|+|Gy|
//  edge_out   out  1      mag_out >= THRESH
//  x_out,y_out out 8 each centre coordinates of the reported window
//  out_valid  out  1      one-cycle pulse; result ports valid
//  abort_err  out  1      one-cycle pulse; incomplete window discarded
// BEHAVIOUR
//  Reset: all outputs 0, tap counter 0, FSM IDLE, pipeline valids 0; async assert, sync release.
//  Collect FSM: IDLE, COLLECT.
//   IDLE: pix_valid&win_start -> store p0, latch x_in/y_in, cnt=1, go COLLECT; other taps ignored.
//   COLLECT: pix_valid&!win_start -> store p[cnt], cnt++. When tap8 is stored, copy p0..p8 and
//    x/y to the compute stage in the same edge; return to IDLE.
//   COLLECT + pix_valid&win_start (cnt<9): discard window, pulse abort_err next cycle,
//    accept the tap as p0 of the new window (cnt=1, relatch x/y).
//   pix_valid=0 cycles in COLLECT are stalls; no timeout.
//  Compute pipeline, independent of collect (a new window may start the cycle after tap8):
//   S1 (tap8 edge +1): Gx=(p2+2p5+p8)-(p0+2p3+p6), Gy=(p6+2p7+p8)-(p0+2p1+p2), signed PIX_W+3 bits.
//   S2 (+2): mag=|Gx|+|Gy| in PIX_W+3 bits unsigned (no overflow), sat to OUT_W, compare THRESH.
//  Latency: out_valid asserts exactly 2 cycles after the edge capturing tap8. Throughput: 1 window per 9 taps.
//  Outputs hold value between pulses. out_valid and abort_err may coincide.
//  Reset mid-window or mid-pipeline: everything cleared, no out_valid for the flushed window.
// STRUCTURE
//  Shared header window_defs.vh holds: TAPS=9, tap index constants P0..P8, Sobel coefficient table.
//  One sub-module, sobel_abs_sat (combinational): abs, add, saturate to OUT_W. FSM, tap regs and pipeline stay in top.
// TESTING
//  Flat window, all taps 100 -> out_valid 2 cycles after tap8, mag_out=0, edge_out=0.
//  Vertical edge: cols 0/x/255 (p0,p3,p6=0; p2,p5,p8=255) -> Gx=1020, mag_out=255 (sat), edge_out=1.
//  Only p5=10, rest 0 -> mag_out=20, edge_out=0; x_out/y_out equal the x_in/y_in given with tap0 (e.g. 37,5).
//  win_start after 4 taps -> abort_err pulse, no out_valid for the discarded window.
//   The new window (9 taps) reports normally.
//  Back-to-back windows with 1-cycle gap and random pix_valid stalls -> one result per window, in order;
//   values match the reference model.
//  rst asserted between tap8 and out_valid -> outputs 0 immediately, no out_valid; next window correct.

Source files
------------

// File: rtl/sobel_window_filter_pkg.sv
// Shared window definitions for the Sobel filter: tap layout, coefficients and collect FSM states.
package sobel_window_filter_pkg;

    localparam int TAPS = 9;

    // Tap indices in raster order, top-left first.
    localparam int P0 = 0;
    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int P3 = 3;
    localparam int P4 = 4;
    localparam int P5 = 5;
    localparam int P6 = 6;
    localparam int P7 = 7;
    localparam int P8 = 8;

    localparam int GX_COEF [TAPS] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    localparam int GY_COEF [TAPS] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

    typedef enum logic {
        StIdle,
        StCollect
    } state_e;

endpackage

// File: rtl/sobel_abs_sat.sv
// Combinational |gx|+|gy|, saturated to OUT_W bits, plus the edge threshold compare.
module sobel_abs_sat #(
    parameter int unsigned GW     = 11,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned THRESH = 128
) (
    input  logic signed [GW-1:0]    gx,
    input  logic signed [GW-1:0]    gy,
    output logic        [OUT_W-1:0] mag,
    output logic                    edge_flag
);

    localparam longint unsigned MAX_VAL = (64'd1 << OUT_W) - 64'd1;

    logic [GW-1:0] abs_x;
    logic [GW-1:0] abs_y;
    logic [GW-1:0] sum;

    always_comb begin
        abs_x = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        abs_y = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        // GW = PIX_W+3 holds 2*4*(2^PIX_W-1), so this sum cannot wrap.
        sum   = abs_x + abs_y;
        if (64'(sum) > MAX_VAL) begin
            mag = '1;
        end else begin
            mag = OUT_W'(sum);
        end
        edge_flag = 64'(mag) >= 64'(THRESH);
    end

endmodule

// File: rtl/sobel_window_filter.sv
// Collects 3x3 tap streams into a window and runs a two-stage Sobel magnitude/edge pipeline.
module sobel_window_filter
    import sobel_window_filter_pkg::*;
#(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned THRESH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      pix_in,
    input  logic             pix_valid,
    input  logic             win_start,
    input  logic [7:0]       x_in,
    input  logic [7:0]       y_in,
    output logic [OUT_W-1:0] mag_out,
    output logic             edge_out,
    output logic [7:0]       x_out,
    output logic [7:0]       y_out,
    output logic             out_valid,
    output logic             abort_err
);

    localparam int unsigned GW = PIX_W + 3;

    logic [PIX_W-1:0] pix;
    logic             unused_pix;

    assign pix        = pix_in[PIX_W-1:0];
    assign unused_pix = ^pix_in;

    // Collect stage
    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [PIX_W-1:0] taps_q [TAPS];
    logic [7:0]       cx_q, cy_q;
    logic             start_tap;
    logic             tap_we;
    logic             win_load;
    logic             abort;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_tap = 1'b0;
        tap_we    = 1'b0;
        win_load  = 1'b0;
        abort     = 1'b0;
        case (state_q)
            StIdle: begin
                if (pix_valid && win_start) begin
                    start_tap = 1'b1;
                    cnt_d     = 4'd1;
                    state_d   = StCollect;
                end
            end
            StCollect: begin
                if (pix_valid) begin
                    if (win_start) begin
                        // Restart: drop the partial window, this tap becomes p0.
                        abort     = 1'b1;
                        start_tap = 1'b1;
                        cnt_d     = 4'd1;
                    end else begin
                        tap_we = 1'b1;
                        if (cnt_q == 4'(P8)) begin
                            win_load = 1'b1;
                            cnt_d    = 4'd0;
                            state_d  = StIdle;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            cx_q    <= 8'd0;
            cy_q    <= 8'd0;
            for (int i = 0; i < TAPS; i++) begin
                taps_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start_tap) begin
                taps_q[P0] <= pix;
                cx_q       <= x_in;
                cy_q       <= y_in;
            end
            if (tap_we) begin
                taps_q[cnt_q] <= pix;
            end
        end
    end

    // Window register handed to the compute pipeline on the tap8 edge
    logic [PIX_W-1:0] win_q [TAPS];
    logic [7:0]       wx_q, wy_q;
    logic             s0_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            wx_q       <= 8'd0;
            wy_q       <= 8'd0;
            for (int i = 0; i < TAPS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            s0_valid_q <= win_load;
            if (win_load) begin
                for (int i = 0; i < P8; i++) begin
                    win_q[i] <= taps_q[i];
                end
                win_q[P8] <= pix;
                wx_q      <= cx_q;
                wy_q      <= cy_q;
            end
        end
    end

    // S1: gradients
    logic signed [GW-1:0] gx_d, gy_d, gx_q, gy_q;
    int                   gx_acc, gy_acc;
    logic [7:0]           s1x_q, s1y_q;
    logic                 s1_valid_q;

    always_comb begin
        gx_acc = 0;
        gy_acc = 0;
        for (int i = 0; i < TAPS; i++) begin
            gx_acc = gx_acc + GX_COEF[i] * int'(win_q[i]);
            gy_acc = gy_acc + GY_COEF[i] * int'(win_q[i]);
        end
        gx_d = GW'(gx_acc);
        gy_d = GW'(gy_acc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gx_q       <= '0;
            gy_q       <= '0;
            s1x_q      <= 8'd0;
            s1y_q      <= 8'd0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s0_valid_q;
            if (s0_valid_q) begin
                gx_q  <= gx_d;
                gy_q  <= gy_d;
                s1x_q <= wx_q;
                s1y_q <= wy_q;
            end
        end
    end

    // S2: magnitude, saturation, threshold
    logic [OUT_W-1:0] mag_d;
    logic             edge_d;

    sobel_abs_sat #(
        .GW     (GW),
        .OUT_W  (OUT_W),
        .THRESH (THRESH)
    ) u_abs_sat (
        .gx        (gx_q),
        .gy        (gy_q),
        .mag       (mag_d),
        .edge_flag (edge_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_out   <= '0;
            edge_out  <= 1'b0;
            x_out     <= 8'd0;
            y_out     <= 8'd0;
            out_valid <= 1'b0;
            abort_err <= 1'b0;
        end else begin
            out_valid <= s1_valid_q;
            abort_err <= abort;
            if (s1_valid_q) begin
                mag_out  <= mag_d;
                edge_out <= edge_d;
                x_out    <= s1x_q;
                y_out    <= s1y_q;
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_filter.sv
// Directed-vector bench for sobel_window_filter with a timing-aware result scoreboard.
module tb_sobel_window_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pix_in;
    logic        pix_valid;
    logic        win_start;
    logic [7:0]  x_in, y_in;
    logic [7:0]  mag_out;
    logic        edge_out;
    logic [7:0]  x_out, y_out;
    logic        out_valid;
    logic        abort_err;

    sobel_window_filter #(
        .PIX_W  (8),
        .OUT_W  (8),
        .THRESH (128)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .win_start (win_start),
        .x_in      (x_in),
        .y_in      (y_in),
        .mag_out   (mag_out),
        .edge_out  (edge_out),
        .x_out     (x_out),
        .y_out     (y_out),
        .out_valid (out_valid),
        .abort_err (abort_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0][7:0] taps;
        logic [7:0]      x;
        logic [7:0]      y;
        logic [7:0]      mag;
        logic            edge_f;
    } vec_t;

    typedef struct {
        logic [7:0] mag;
        logic       edge_f;
        logic [7:0] x;
        logic [7:0] y;
        int         due;
    } exp_t;

    localparam int NVEC = 10;

    vec_t vecs [NVEC];
    exp_t sb [$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   abort_due = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Independent reference written out as the textbook Sobel sums.
    function automatic void ref_model(input logic [8:0][7:0] t, output logic [7:0] m,
                                      output logic e);
        int gx, gy, s;
        gx = (int'(t[2]) + 2 * int'(t[5]) + int'(t[8])) - (int'(t[0]) + 2 * int'(t[3]) + int'(t[6]));
        gy = (int'(t[6]) + 2 * int'(t[7]) + int'(t[8])) - (int'(t[0]) + 2 * int'(t[1]) + int'(t[2]));
        s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (s > 255) s = 255;
        m = 8'(s);
        e = (s >= 128);
    endfunction

    // Scoreboard: out_valid must appear exactly on the due cycle, abort_err likewise.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            logic exp_v;
            logic exp_a;
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            if (out_valid || exp_v) begin
                chk("out_valid", 32'(out_valid), 32'(exp_v));
                if (exp_v) begin
                    if (out_valid) begin
                        chk("mag_out", 32'(mag_out), 32'(sb[0].mag));
                        chk("edge_out", 32'(edge_out), 32'(sb[0].edge_f));
                        chk("x_out", 32'(x_out), 32'(sb[0].x));
                        chk("y_out", 32'(y_out), 32'(sb[0].y));
                    end
                    void'(sb.pop_front());
                end
            end
            exp_a = (cyc == abort_due);
            if (abort_err || exp_a) chk("abort_err", 32'(abort_err), 32'(exp_a));
        end
    end

    task automatic send_tap(input logic [7:0] p, input logic start, input logic [7:0] x,
                            input logic [7:0] y);
        @(negedge clk);
        pix_valid = 1'b1;
        win_start = start;
        pix_in    = {8'($urandom), p};
        x_in      = x;
        y_in      = y;
    endtask

    task automatic idle();
        @(negedge clk);
        pix_valid = 1'b0;
        win_start = 1'($urandom);
        pix_in    = 16'($urandom);
        x_in      = 8'($urandom);
        y_in      = 8'($urandom);
    endtask

    task automatic send_window(input vec_t v, input int stall_max, input int gap,
                               input bit expect_abort);
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) repeat ($urandom_range(0, stall_max)) idle();
            if (i == 0) send_tap(v.taps[i], 1'b1, v.x, v.y);
            else send_tap(v.taps[i], 1'b0, 8'($urandom), 8'($urandom));
            if (i == 0 && expect_abort) abort_due = cyc + 1;
        end
        e.mag    = v.mag;
        e.edge_f = v.edge_f;
        e.x      = v.x;
        e.y      = v.y;
        e.due    = cyc + 3;
        sb.push_back(e);
        repeat (gap) idle();
    endtask

    task automatic set_v(input int idx, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] m, input logic e);
        vecs[idx].taps   = '0;
        vecs[idx].x      = x;
        vecs[idx].y      = y;
        vecs[idx].mag    = m;
        vecs[idx].edge_f = e;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " mag_out"}, 32'(mag_out), 32'd0);
        chk({tag, " edge_out"}, 32'(edge_out), 32'd0);
        chk({tag, " x_out"}, 32'(x_out), 32'd0);
        chk({tag, " y_out"}, 32'(y_out), 32'd0);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " abort_err"}, 32'(abort_err), 32'd0);
    endtask

    initial begin
        vec_t rv;
        rst       = 1'b1;
        pix_in    = '0;
        pix_valid = 1'b0;
        win_start = 1'b0;
        x_in      = '0;
        y_in      = '0;

        // Hand-computed vectors: taps, centre, expected mag/edge.
        set_v(0, 8'd10, 8'd20, 8'd0, 1'b0);
        for (int i = 0; i < 9; i++) vecs[0].taps[i] = 8'd100;
        set_v(1, 8'd11, 8'd21, 8'd255, 1'b1);
        vecs[1].taps[2] = 8'd255; vecs[1].taps[5] = 8'd255; vecs[1].taps[8] = 8'd255;
        vecs[1].taps[1] = 8'd100; vecs[1].taps[4] = 8'd100; vecs[1].taps[7] = 8'd100;
        set_v(2, 8'd37, 8'd5, 8'd20, 1'b0);
        vecs[2].taps[5] = 8'd10;
        set_v(3, 8'd12, 8'd22, 8'd255, 1'b1);
        vecs[3].taps[6] = 8'd255; vecs[3].taps[7] = 8'd255; vecs[3].taps[8] = 8'd255;
        set_v(4, 8'd13, 8'd23, 8'd100, 1'b0);
        vecs[4].taps[0] = 8'd50;
        set_v(5, 8'd14, 8'd24, 8'd128, 1'b1);
        vecs[5].taps[1] = 8'd64;
        set_v(6, 8'd15, 8'd25, 8'd126, 1'b0);
        vecs[6].taps[1] = 8'd63;
        set_v(7, 8'd16, 8'd26, 8'd255, 1'b1);
        vecs[7].taps[2] = 8'd255;
        set_v(8, 8'd17, 8'd27, 8'd0, 1'b0);
        vecs[8].taps[4] = 8'd200;
        set_v(9, 8'd18, 8'd28, 8'd128, 1'b1);
        vecs[9].taps[5] = 8'd32; vecs[9].taps[7] = 8'd32;

        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;

        // A tap without win_start while idle must be ignored.
        send_tap(8'd77, 1'b0, 8'd1, 8'd2);
        idle();

        for (int k = 0; k < NVEC; k++) send_window(vecs[k], 0, 3, 1'b0);
        repeat (4) idle();
        chk("hold mag_out", 32'(mag_out), 32'(vecs[NVEC-1].mag));
        chk("hold x_out", 32'(x_out), 32'(vecs[NVEC-1].x));

        // Abort: four taps of a window, then a fresh win_start.
        send_tap(8'd255, 1'b1, 8'd99, 8'd98);
        for (int i = 1; i < 4; i++) send_tap(8'd255, 1'b0, 8'd0, 8'd0);
        send_window(vecs[2], 0, 4, 1'b1);

        // Back-to-back windows with random stalls and 0/1-cycle gaps.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 9; i++) rv.taps[i] = 8'($urandom_range(0, 255));
            rv.x = 8'($urandom);
            rv.y = 8'($urandom);
            ref_model(rv.taps, rv.mag, rv.edge_f);
            send_window(rv, 2, $urandom_range(0, 1), 1'b0);
        end
        repeat (4) idle();

        // Reset between tap8 and out_valid flushes the pipeline.
        send_window(vecs[1], 0, 0, 1'b0);
        @(posedge clk);
        #2;
        rst       = 1'b1;
        pix_valid = 1'b0;
        sb.delete();
        #1;
        chk_outputs_zero("mid-pipe reset");
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (4) idle();
        send_window(vecs[5], 1, 4, 1'b0);

        repeat (4) idle();
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
